// File: rtl/jtdd_rom_arb_if.sv
// Bundle of the three CPU ROM buses and the SDRAM read port.
// The arbiter connects through the slave modport; the bench drives through master.
interface jtdd_rom_arb_if #(
   parameter int MAIN_AW  = 18,
   parameter int SND_AW   = 15,
   parameter int MCU_AW   = 14,
   parameter int SDRAM_AW = 22
);
   logic                flush;
   logic                main_cs;
   logic [MAIN_AW-1:0]  main_addr;
   logic [7:0]          main_dout;
   logic                main_ok;
   logic                snd_cs;
   logic [SND_AW-1:0]   snd_addr;
   logic [7:0]          snd_dout;
   logic                snd_ok;
   logic                mcu_cs;
   logic [MCU_AW-1:0]   mcu_addr;
   logic [7:0]          mcu_dout;
   logic                mcu_ok;
   logic                sdram_req;
   logic [SDRAM_AW-1:0] sdram_addr;
   logic                sdram_ack;
   logic                data_rdy;
   logic [15:0]         sdram_din;

   modport slave (
      input  flush,
      input  main_cs, main_addr,
      output main_dout, main_ok,
      input  snd_cs, snd_addr,
      output snd_dout, snd_ok,
      input  mcu_cs, mcu_addr,
      output mcu_dout, mcu_ok,
      output sdram_req, sdram_addr,
      input  sdram_ack, data_rdy, sdram_din
   );

   modport master (
      output flush,
      output main_cs, main_addr,
      input  main_dout, main_ok,
      output snd_cs, snd_addr,
      input  snd_dout, snd_ok,
      output mcu_cs, mcu_addr,
      input  mcu_dout, mcu_ok,
      input  sdram_req, sdram_addr,
      output sdram_ack, data_rdy, sdram_din
   );
endinterface

// File: rtl/jtdd_rom_arb.sv
// Shares one SDRAM read port among the main, sound and MCU ROM clients.
// Each client keeps a one-word cache; misses are serviced round-robin.
module jtdd_rom_arb #(
   parameter int MAIN_AW  = 18,
   parameter int SND_AW   = 15,
   parameter int MCU_AW   = 14,
   parameter int SDRAM_AW = 22,
   parameter logic [SDRAM_AW-1:0] MAIN_OFS = 22'h00000,
   parameter logic [SDRAM_AW-1:0] SND_OFS  = 22'h20000,
   parameter logic [SDRAM_AW-1:0] MCU_OFS  = 22'h28000
) (
   input logic            clk,
   input logic            rst,
   jtdd_rom_arb_if.slave  bus
);
   localparam int AW01 = MAIN_AW > SND_AW ? MAIN_AW : SND_AW;
   localparam int TW   = (AW01 > MCU_AW ? AW01 : MCU_AW) - 1;

   localparam logic [1:0] ID_MAIN = 2'd0;
   localparam logic [1:0] ID_SND  = 2'd1;
   localparam logic [1:0] ID_MCU  = 2'd2;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t              state_q, state_d;
   logic                req_q, req_d;
   logic [SDRAM_AW-1:0] saddr_q, saddr_d;
   logic [1:0]          gnt_q, gnt_d;
   logic [1:0]          last_q, last_d;
   logic [TW-1:0]       tag_q, tag_d;
   logic                flushed_q, flushed_d;

   logic                main_valid_q, main_valid_d;
   logic [MAIN_AW-2:0]  main_tag_q, main_tag_d;
   logic [15:0]         main_data_q, main_data_d;
   logic                snd_valid_q, snd_valid_d;
   logic [SND_AW-2:0]   snd_tag_q, snd_tag_d;
   logic [15:0]         snd_data_q, snd_data_d;
   logic                mcu_valid_q, mcu_valid_d;
   logic [MCU_AW-2:0]   mcu_tag_q, mcu_tag_d;
   logic [15:0]         mcu_data_q, mcu_data_d;

   logic                main_hit, snd_hit, mcu_hit;
   logic [2:0]          miss;
   logic [1:0]          pick;
   logic                fill, keep;

   assign main_hit = bus.main_cs & main_valid_q
                   & (main_tag_q == bus.main_addr[MAIN_AW-1:1]);
   assign snd_hit  = bus.snd_cs & snd_valid_q
                   & (snd_tag_q == bus.snd_addr[SND_AW-1:1]);
   assign mcu_hit  = bus.mcu_cs & mcu_valid_q
                   & (mcu_tag_q == bus.mcu_addr[MCU_AW-1:1]);

   assign miss = {bus.mcu_cs & ~mcu_hit,
                  bus.snd_cs & ~snd_hit,
                  bus.main_cs & ~main_hit};

   assign bus.main_ok   = main_hit;
   assign bus.snd_ok    = snd_hit;
   assign bus.mcu_ok    = mcu_hit;
   assign bus.main_dout = bus.main_addr[0] ? main_data_q[15:8] : main_data_q[7:0];
   assign bus.snd_dout  = bus.snd_addr[0]  ? snd_data_q[15:8]  : snd_data_q[7:0];
   assign bus.mcu_dout  = bus.mcu_addr[0]  ? mcu_data_q[15:8]  : mcu_data_q[7:0];

   assign bus.sdram_req  = req_q;
   assign bus.sdram_addr = saddr_q;

   // Round-robin: the first missing client after the last one served
   always_comb begin
      pick = ID_MAIN;
      unique case (last_q)
         ID_MAIN: pick = miss[1] ? ID_SND  : miss[2] ? ID_MCU  : ID_MAIN;
         ID_SND:  pick = miss[2] ? ID_MCU  : miss[0] ? ID_MAIN : ID_SND;
         default: pick = miss[0] ? ID_MAIN : miss[1] ? ID_SND  : ID_MCU;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      saddr_d   = saddr_q;
      gnt_d     = gnt_q;
      last_d    = last_q;
      tag_d     = tag_q;
      flushed_d = flushed_q | bus.flush;
      fill      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|miss) begin
               gnt_d     = pick;
               req_d     = 1'b1;
               state_d   = REQ;
               flushed_d = bus.flush;
               unique case (pick)
                  ID_MAIN: begin
                     tag_d   = TW'(bus.main_addr[MAIN_AW-1:1]);
                     saddr_d = MAIN_OFS + SDRAM_AW'(bus.main_addr[MAIN_AW-1:1]);
                  end
                  ID_SND: begin
                     tag_d   = TW'(bus.snd_addr[SND_AW-1:1]);
                     saddr_d = SND_OFS + SDRAM_AW'(bus.snd_addr[SND_AW-1:1]);
                  end
                  default: begin
                     tag_d   = TW'(bus.mcu_addr[MCU_AW-1:1]);
                     saddr_d = MCU_OFS + SDRAM_AW'(bus.mcu_addr[MCU_AW-1:1]);
                  end
               endcase
            end
         end
         REQ: begin
            if (bus.sdram_ack) begin
               req_d = 1'b0;
               if (bus.data_rdy) begin
                  fill    = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         default: begin
            if (bus.data_rdy) begin
               fill    = 1'b1;
               state_d = IDLE;
            end
         end
      endcase
      if (fill) last_d = gnt_q;
   end

   // A fill is dropped if any flush was seen since its grant
   assign keep = fill & ~bus.flush & ~flushed_q;

   always_comb begin
      main_valid_d = main_valid_q & ~bus.flush;
      main_tag_d   = main_tag_q;
      main_data_d  = main_data_q;
      snd_valid_d  = snd_valid_q & ~bus.flush;
      snd_tag_d    = snd_tag_q;
      snd_data_d   = snd_data_q;
      mcu_valid_d  = mcu_valid_q & ~bus.flush;
      mcu_tag_d    = mcu_tag_q;
      mcu_data_d   = mcu_data_q;
      if (keep) begin
         unique case (gnt_q)
            ID_MAIN: begin
               main_valid_d = 1'b1;
               main_tag_d   = tag_q[MAIN_AW-2:0];
               main_data_d  = bus.sdram_din;
            end
            ID_SND: begin
               snd_valid_d = 1'b1;
               snd_tag_d   = tag_q[SND_AW-2:0];
               snd_data_d  = bus.sdram_din;
            end
            default: begin
               mcu_valid_d = 1'b1;
               mcu_tag_d   = tag_q[MCU_AW-2:0];
               mcu_data_d  = bus.sdram_din;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         req_q        <= 1'b0;
         saddr_q      <= '0;
         gnt_q        <= ID_MAIN;
         last_q       <= ID_MCU;
         tag_q        <= '0;
         flushed_q    <= 1'b0;
         main_valid_q <= 1'b0;
         main_tag_q   <= '0;
         main_data_q  <= '0;
         snd_valid_q  <= 1'b0;
         snd_tag_q    <= '0;
         snd_data_q   <= '0;
         mcu_valid_q  <= 1'b0;
         mcu_tag_q    <= '0;
         mcu_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         saddr_q      <= saddr_d;
         gnt_q        <= gnt_d;
         last_q       <= last_d;
         tag_q        <= tag_d;
         flushed_q    <= flushed_d;
         main_valid_q <= main_valid_d;
         main_tag_q   <= main_tag_d;
         main_data_q  <= main_data_d;
         snd_valid_q  <= snd_valid_d;
         snd_tag_q    <= snd_tag_d;
         snd_data_q   <= snd_data_d;
         mcu_valid_q  <= mcu_valid_d;
         mcu_tag_q    <= mcu_tag_d;
         mcu_data_q   <= mcu_data_d;
      end
   end
endmodule

// File: tb/tb_jtdd_rom_arb.sv
// Directed bench for jtdd_rom_arb: cache hits, round-robin order,
// ack stalls, address change, flush and reset mid-transaction.
module tb_jtdd_rom_arb;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   jtdd_rom_arb_if bus ();

   jtdd_rom_arb dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for sdram_req, then check the requested address
   task automatic wait_req(input string tag, input logic [21:0] exp_addr);
      int n = 0;
      while (bus.sdram_req !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      chk({tag, "_req"}, 32'(bus.sdram_req), 32'h1);
      chk({tag, "_addr"}, 32'(bus.sdram_addr), 32'(exp_addr));
   endtask

   // Immediate ack, data on the next cycle
   task automatic serve(input logic [15:0] d);
      bus.sdram_ack = 1'b1;
      tick();
      bus.sdram_ack = 1'b0;
      bus.data_rdy  = 1'b1;
      bus.sdram_din = d;
      tick();
      bus.data_rdy  = 1'b0;
   endtask

   initial begin
      bus.flush     = 1'b0;
      bus.main_cs   = 1'b0;
      bus.main_addr = '0;
      bus.snd_cs    = 1'b0;
      bus.snd_addr  = '0;
      bus.mcu_cs    = 1'b0;
      bus.mcu_addr  = '0;
      bus.sdram_ack = 1'b0;
      bus.data_rdy  = 1'b0;
      bus.sdram_din = '0;
      tick();
      tick();
      chk("rst_req", 32'(bus.sdram_req), 32'h0);
      chk("rst_addr", 32'(bus.sdram_addr), 32'h0);
      chk("rst_main_ok", 32'(bus.main_ok), 32'h0);
      rst = 1'b0;

      // 1: single miss, byte select, then hit on the other byte
      bus.main_cs   = 1'b1;
      bus.main_addr = 18'h08001;
      #1;
      chk("t1_req_c0", 32'(bus.sdram_req), 32'h0);
      chk("t1_ok_c0", 32'(bus.main_ok), 32'h0);
      tick();
      chk("t1_req_c1", 32'(bus.sdram_req), 32'h1);
      chk("t1_addr", 32'(bus.sdram_addr), 32'h04000);
      serve(16'hA55A);
      chk("t1_ok", 32'(bus.main_ok), 32'h1);
      chk("t1_dout_hi", 32'(bus.main_dout), 32'hA5);
      bus.main_addr = 18'h08000;
      #1;
      chk("t1_ok_lo", 32'(bus.main_ok), 32'h1);
      chk("t1_dout_lo", 32'(bus.main_dout), 32'h5A);
      tick();
      chk("t1_no_req", 32'(bus.sdram_req), 32'h0);

      // 2: three simultaneous misses, main re-misses after its fill
      rst = 1'b1;
      #1;
      chk("t2_rst_ok", 32'(bus.main_ok), 32'h0);
      tick();
      rst = 1'b0;
      bus.main_addr = 18'h00100;
      bus.snd_cs    = 1'b1;
      bus.snd_addr  = 15'h0202;
      bus.mcu_cs    = 1'b1;
      bus.mcu_addr  = 14'h0006;
      tick();
      chk("t2_g0_req", 32'(bus.sdram_req), 32'h1);
      chk("t2_g0_addr", 32'(bus.sdram_addr), 32'h00080);
      serve(16'h1234);
      chk("t2_main_ok", 32'(bus.main_ok), 32'h1);
      chk("t2_main_dout", 32'(bus.main_dout), 32'h34);
      bus.main_addr = 18'h00102;
      wait_req("t2_g1", 22'h20101);
      serve(16'hBEEF);
      chk("t2_snd_ok", 32'(bus.snd_ok), 32'h1);
      chk("t2_snd_dout", 32'(bus.snd_dout), 32'hEF);
      chk("t2_mcu_ok0", 32'(bus.mcu_ok), 32'h0);
      wait_req("t2_g2", 22'h28003);
      serve(16'hCAFE);
      chk("t2_mcu_ok", 32'(bus.mcu_ok), 32'h1);
      chk("t2_mcu_dout", 32'(bus.mcu_dout), 32'hFE);
      wait_req("t2_g3", 22'h00081);
      serve(16'h5678);
      chk("t2_main2_ok", 32'(bus.main_ok), 32'h1);
      chk("t2_main2_dout", 32'(bus.main_dout), 32'h78);
      chk("t2_snd_keep", 32'(bus.snd_ok), 32'h1);

      // 3: ack delayed 5 cycles
      bus.main_addr = 18'h00200;
      wait_req("t3", 22'h00100);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t3_hold_req", 32'(bus.sdram_req), 32'h1);
         chk("t3_hold_addr", 32'(bus.sdram_addr), 32'h00100);
      end
      bus.sdram_ack = 1'b1;
      tick();
      bus.sdram_ack = 1'b0;
      chk("t3_req_drop", 32'(bus.sdram_req), 32'h0);
      bus.data_rdy  = 1'b1;
      bus.sdram_din = 16'h7788;
      tick();
      bus.data_rdy  = 1'b0;
      chk("t3_ok", 32'(bus.main_ok), 32'h1);
      chk("t3_dout", 32'(bus.main_dout), 32'h88);
      bus.snd_cs = 1'b0;
      bus.mcu_cs = 1'b0;
      #1;
      chk("t3_snd_ok_cs0", 32'(bus.snd_ok), 32'h0);

      // 4: address changes while waiting for data
      bus.main_addr = 18'h00010;
      wait_req("t4", 22'h00008);
      bus.sdram_ack = 1'b1;
      tick();
      bus.sdram_ack = 1'b0;
      bus.main_addr = 18'h00020;
      bus.data_rdy  = 1'b1;
      bus.sdram_din = 16'h1111;
      tick();
      bus.data_rdy  = 1'b0;
      chk("t4_ok_stale", 32'(bus.main_ok), 32'h0);
      wait_req("t4_re", 22'h00010);
      serve(16'h2222);
      chk("t4_ok", 32'(bus.main_ok), 32'h1);
      chk("t4_dout", 32'(bus.main_dout), 32'h22);

      // 5: flush during WAIT discards the fill
      bus.main_addr = 18'h00030;
      wait_req("t5", 22'h00018);
      bus.sdram_ack = 1'b1;
      tick();
      bus.sdram_ack = 1'b0;
      bus.flush = 1'b1;
      tick();
      bus.flush     = 1'b0;
      bus.data_rdy  = 1'b1;
      bus.sdram_din = 16'h3333;
      tick();
      bus.data_rdy  = 1'b0;
      chk("t5_ok_disc", 32'(bus.main_ok), 32'h0);
      wait_req("t5_re", 22'h00018);
      serve(16'h4444);
      chk("t5_ok", 32'(bus.main_ok), 32'h1);
      chk("t5_dout", 32'(bus.main_dout), 32'h44);

      // 6: reset while in REQ; late ack/data ignored
      bus.main_addr = 18'h00040;
      wait_req("t6", 22'h00020);
      rst = 1'b1;
      #1;
      chk("t6_req", 32'(bus.sdram_req), 32'h0);
      chk("t6_addr", 32'(bus.sdram_addr), 32'h0);
      chk("t6_ok", 32'(bus.main_ok), 32'h0);
      bus.main_cs = 1'b0;
      tick();
      rst = 1'b0;
      bus.sdram_ack = 1'b1;
      bus.data_rdy  = 1'b1;
      bus.sdram_din = 16'h9999;
      tick();
      bus.sdram_ack = 1'b0;
      bus.data_rdy  = 1'b0;
      bus.main_cs   = 1'b1;
      #1;
      chk("t6_late_ok", 32'(bus.main_ok), 32'h0);
      chk("t6_late_req", 32'(bus.sdram_req), 32'h0);
      wait_req("t6_re", 22'h00020);
      serve(16'h5555);
      chk("t6_fill_ok", 32'(bus.main_ok), 32'h1);
      chk("t6_fill_dout", 32'(bus.main_dout), 32'h55);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
